// File: rtl/time_stamp_unit_pkg.sv
// Shared types and constants for the interrupt time-stamp unit.
//   word / CsrAddrT / MonoTimerT / CsrOpT : CSR-path and timer types.
//   TimeStampModeT                        : per-channel capture edge selection.
//   Default* / *Offset / StatusOverrunLsb : defaults and CSR layout constants.
package time_stamp_unit_pkg;

  typedef logic [31:0] word;
  typedef logic [11:0] CsrAddrT;
  typedef logic [63:0] MonoTimerT;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSRRW    = 2'b01,
    CSRRS    = 2'b10,
    CSRRC    = 2'b11
  } CsrOpT;

  typedef enum logic [1:0] {
    TS_OFF  = 2'b00,
    TS_RISE = 2'b01,
    TS_FALL = 2'b10,
    TS_BOTH = 2'b11
  } TimeStampModeT;

  localparam int unsigned DefaultNumChannels = 8;
  localparam int unsigned DefaultStampWidth  = 16;
  localparam int unsigned DefaultPreScaler   = 4;
  localparam CsrAddrT     DefaultCsrBase     = 12'h7C0;

  // STATUS carries overrun flags starting at this bit.
  localparam int unsigned StatusOverrunLsb = 16;

  // STATUS and MODE sit directly after the stamp registers.
  localparam int unsigned StatusAddrOffset = 0;
  localparam int unsigned ModeAddrOffset   = 1;

endpackage

// File: rtl/time_stamp_unit_if.sv
// CSR access bundle between the instruction pipeline and the time-stamp unit.
//   csr_enable : CSR instruction active this cycle
//   csr_addr   : CSR address
//   csr_op     : CSRRW / CSRRS / CSRRC
//   rs1_data   : write operand
//   csr_out    : combinational read data
// master = pipeline side, slave = time-stamp unit.
interface time_stamp_unit_if;
  import time_stamp_unit_pkg::*;

  logic    csr_enable;
  CsrAddrT csr_addr;
  CsrOpT   csr_op;
  word     rs1_data;
  word     csr_out;

  modport master (
    output csr_enable, csr_addr, csr_op, rs1_data,
    input  csr_out
  );

  modport slave (
    input  csr_enable, csr_addr, csr_op, rs1_data,
    output csr_out
  );

endinterface

// File: rtl/time_stamp_channel.sv
// One capture channel: edge detection on pend, stamp capture, valid/overrun.
//   clk, reset : clock, synchronous active-high reset
//   pend       : pending line of this vector
//   mode       : edge selection (off / rise / fall / both)
//   stamp_in   : prescaled, truncated timer value
//   read_clr   : stamp CSR read this cycle (clears valid)
//   ovf_clr    : W1C request for overrun
//   stamp, valid, overrun : registered channel state
module time_stamp_channel
  import time_stamp_unit_pkg::*;
#(
  parameter int unsigned StampWidth = DefaultStampWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pend,
  input  TimeStampModeT         mode,
  input  logic [StampWidth-1:0] stamp_in,
  input  logic                  read_clr,
  input  logic                  ovf_clr,
  output logic [StampWidth-1:0] stamp,
  output logic                  valid,
  output logic                  overrun
);

  logic                  old_pend_q, old_pend_d;
  logic [StampWidth-1:0] stamp_q, stamp_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [1:0]            mode_bits;
  logic                  rise, fall, edge_hit;

  assign mode_bits = mode;

  always_comb begin
    rise       = ~old_pend_q & pend;
    fall       = old_pend_q & ~pend;
    edge_hit   = (rise & mode_bits[0]) | (fall & mode_bits[1]);
    old_pend_d = pend;
    stamp_d    = stamp_q;
    valid_d    = valid_q;
    if (edge_hit) begin
      stamp_d = stamp_in;
      valid_d = 1'b1;
    end else if (read_clr) begin
      valid_d = 1'b0;
    end
    // A same-cycle read consumes the old stamp, so no data is lost; a new
    // overrun takes priority over a simultaneous clear.
    overrun_d = (edge_hit & valid_q & ~read_clr) | (overrun_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      old_pend_q <= 1'b0;
      stamp_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      old_pend_q <= old_pend_d;
      stamp_q    <= stamp_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign stamp   = stamp_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/time_stamp_unit.sv
// Per-vector interrupt time-stamper with CSR access.
//   clk, reset : clock, synchronous active-high reset
//   mono_timer : free-running monotonic timer
//   pend       : per-vector pending lines (unpacked)
//   csr        : CSR access bundle (slave side), csr_out is combinational
// Address map: stamp[k] at CsrBase+k, STATUS after the stamps, MODE after STATUS.
module time_stamp_unit
  import time_stamp_unit_pkg::*;
#(
  parameter int unsigned NumChannels = DefaultNumChannels,
  parameter int unsigned StampWidth  = DefaultStampWidth,
  parameter int unsigned PreScaler   = DefaultPreScaler,
  parameter CsrAddrT     CsrBase     = DefaultCsrBase
) (
  input  logic               clk,
  input  logic               reset,
  input  MonoTimerT          mono_timer,
  input  logic               pend [NumChannels],
  time_stamp_unit_if.slave   csr
);

  localparam CsrAddrT StatusAddr = CsrAddrT'(CsrBase + NumChannels + StatusAddrOffset);
  localparam CsrAddrT ModeAddr   = CsrAddrT'(CsrBase + NumChannels + ModeAddrOffset);
  localparam logic [2*NumChannels-1:0] ModeReset = {NumChannels{2'b01}};

  logic [2*NumChannels-1:0] mode_q, mode_d;
  logic [StampWidth-1:0]    stamp_in;
  logic [StampWidth-1:0]    stamp [NumChannels];
  logic [NumChannels-1:0]   valid, overrun;
  logic [NumChannels-1:0]   stamp_sel, read_clr, ovf_clr;
  logic                     rs1_nz, write_en;
  word                      rd_data;

  assign stamp_in = StampWidth'(mono_timer >> PreScaler);
  assign rs1_nz   = |csr.rs1_data;

  // Address decode and write control.
  always_comb begin
    stamp_sel = '0;
    for (int unsigned k = 0; k < NumChannels; k++) begin
      if (csr.csr_addr == CsrAddrT'(CsrBase + k)) stamp_sel[k] = 1'b1;
    end
    read_clr = csr.csr_enable ? stamp_sel : '0;

    write_en = csr.csr_enable &
               ((csr.csr_op == CSRRW) |
                (((csr.csr_op == CSRRS) | (csr.csr_op == CSRRC)) & rs1_nz));

    mode_d = mode_q;
    if (write_en && (csr.csr_addr == ModeAddr)) begin
      case (csr.csr_op)
        CSRRW:   mode_d = csr.rs1_data[2*NumChannels-1:0];
        CSRRS:   mode_d = mode_q | csr.rs1_data[2*NumChannels-1:0];
        CSRRC:   mode_d = mode_q & ~csr.rs1_data[2*NumChannels-1:0];
        default: mode_d = mode_q;
      endcase
    end

    // Overrun is W1C for RW and RS only; RC never clears status.
    ovf_clr = '0;
    if (csr.csr_enable && (csr.csr_addr == StatusAddr) &&
        ((csr.csr_op == CSRRW) || (csr.csr_op == CSRRS))) begin
      ovf_clr = csr.rs1_data[StatusOverrunLsb +: NumChannels];
    end
  end

  // Read mux.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NumChannels; k++) begin
      if (stamp_sel[k]) rd_data = word'(stamp[k]);
    end
    if (csr.csr_addr == StatusAddr) begin
      rd_data[NumChannels-1:0]                = valid;
      rd_data[StatusOverrunLsb +: NumChannels] = overrun;
    end
    if (csr.csr_addr == ModeAddr) begin
      rd_data[2*NumChannels-1:0] = mode_q;
    end
  end

  assign csr.csr_out = rd_data;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= ModeReset;
    else       mode_q <= mode_d;
  end

  for (genvar k = 0; k < NumChannels; k++) begin : g_chan
    time_stamp_channel #(
      .StampWidth(StampWidth)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .pend     (pend[k]),
      .mode     (TimeStampModeT'(mode_q[2*k +: 2])),
      .stamp_in (stamp_in),
      .read_clr (read_clr[k]),
      .ovf_clr  (ovf_clr[k]),
      .stamp    (stamp[k]),
      .valid    (valid[k]),
      .overrun  (overrun[k])
    );
  end

endmodule

// File: tb/tb_time_stamp_unit.sv
module tb_time_stamp_unit;
  import time_stamp_unit_pkg::*;

  localparam int unsigned NCH  = 8;
  localparam int unsigned BASE = 12'h7C0;

  logic      clk;
  logic      reset;
  MonoTimerT mono_timer;
  logic      pend [NCH];

  time_stamp_unit_if csr ();

  time_stamp_unit #(
    .NumChannels(NCH),
    .StampWidth (16),
    .PreScaler  (4),
    .CsrBase    (12'h7C0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mono_timer(mono_timer),
    .pend      (pend),
    .csr       (csr.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state, advanced by the rules at every clock edge.
  int unsigned m_stamp [NCH];
  bit          m_valid [NCH];
  bit          m_ovr   [NCH];
  bit          m_old   [NCH];
  bit [15:0]   m_mode;

  function automatic int unsigned model_read(input int unsigned addr);
    int unsigned off;
    int unsigned r;
    r = 0;
    if (addr < BASE) return 0;
    off = addr - BASE;
    if (off < NCH) r = m_stamp[off];
    else if (off == NCH) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (m_valid[k]) r = r + (1 << k);
        if (m_ovr[k])   r = r + (1 << (16 + k));
      end
    end else if (off == NCH + 1) r = m_mode;
    return r;
  endfunction

  task automatic model_step();
    int unsigned off;
    bit en, rd, edge_k, rise, fall, clr;
    int unsigned rs1, mode_k;
    CsrOpT op;
    en  = csr.csr_enable;
    op  = csr.csr_op;
    rs1 = csr.rs1_data;
    off = int'(csr.csr_addr) - BASE;
    if (reset) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        m_stamp[k] = 0; m_valid[k] = 0; m_ovr[k] = 0; m_old[k] = 0;
      end
      m_mode = 16'h5555;
      return;
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      mode_k = (m_mode >> (2 * k)) & 3;
      rise   = !m_old[k] && pend[k];
      fall   = m_old[k] && !pend[k];
      edge_k = (rise && (mode_k & 1) != 0) || (fall && (mode_k & 2) != 0);
      rd     = en && (off == k);
      clr    = en && (off == NCH) && (op == CSRRW || op == CSRRS) && (((rs1 >> (16 + k)) & 1) != 0);
      if (edge_k && m_valid[k] && !rd) m_ovr[k] = 1;
      else if (clr) m_ovr[k] = 0;
      if (edge_k) begin
        m_stamp[k] = int'((mono_timer / 16) % 65536);
        m_valid[k] = 1;
      end else if (rd) m_valid[k] = 0;
      m_old[k] = pend[k];
    end
    if (en && off == NCH + 1) begin
      if (op == CSRRW) m_mode = rs1[15:0];
      else if (op == CSRRS) m_mode = m_mode | rs1[15:0];
      else if (op == CSRRC) m_mode = m_mode & ~rs1[15:0];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_csr(input bit en, input int unsigned addr, input CsrOpT op, input int unsigned data);
    csr.csr_enable = en;
    csr.csr_addr   = CsrAddrT'(addr);
    csr.csr_op     = op;
    csr.rs1_data   = data;
    #1;
  endtask

  task automatic idle();
    set_csr(1'b0, BASE + 20, CSR_NONE, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL reset_status act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    set_csr(1'b1, BASE + NCH + 1, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h5555) begin errors++; $display("FAIL reset_mode act=%h exp=%h", csr.csr_out, 32'h5555); end
    tick();
    set_csr(1'b1, BASE + 0, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL reset_stamp0 act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    idle();
  endtask

  task automatic test_rise_capture();
    mono_timer = 64'h1230;
    pend[0] = 1'b1;
    tick();
    mono_timer = 64'h2000;
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h1) begin errors++; $display("FAIL rise_status act=%h exp=%h", csr.csr_out, 32'h1); end
    tick();
    set_csr(1'b1, BASE + 0, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0123) begin errors++; $display("FAIL rise_stamp0 act=%h exp=%h", csr.csr_out, 32'h0123); end
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL rise_status_clr act=%h exp=%h", csr.csr_out, 32'h0); end
    pend[0] = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_fall_both();
    set_csr(1'b1, BASE + NCH + 1, CSRRW, 32'h5559);
    tick();
    idle();
    mono_timer = 64'h2000; pend[1] = 1'b1;
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL fall_no_rise act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    idle();
    mono_timer = 64'h2100;
    tick();
    mono_timer = 64'h3450; pend[1] = 1'b0;
    tick();
    set_csr(1'b1, BASE + 1, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0345) begin errors++; $display("FAIL fall_stamp1 act=%h exp=%h", csr.csr_out, 32'h0345); end
    tick();
    set_csr(1'b1, BASE + NCH + 1, CSRRW, 32'h555D);
    tick();
    idle();
    mono_timer = 64'h4000; pend[1] = 1'b1;
    tick();
    mono_timer = 64'h5000; pend[1] = 1'b0;
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0002_0002) begin errors++; $display("FAIL both_status act=%h exp=%h", csr.csr_out, 32'h0002_0002); end
    tick();
    set_csr(1'b1, BASE + 1, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0500) begin errors++; $display("FAIL both_stamp1 act=%h exp=%h", csr.csr_out, 32'h0500); end
    tick();
    idle();
  endtask

  task automatic test_overrun_w1c();
    mono_timer = 64'h6000; pend[2] = 1'b1;
    tick();
    pend[2] = 1'b0;
    tick();
    mono_timer = 64'h7770; pend[2] = 1'b1;
    tick();
    pend[2] = 1'b0;
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0006_0004) begin errors++; $display("FAIL ovr_status act=%h exp=%h", csr.csr_out, 32'h0006_0004); end
    tick();
    set_csr(1'b1, BASE + NCH, CSRRW, 32'h0004_0000);
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0002_0004) begin errors++; $display("FAIL ovr_w1c act=%h exp=%h", csr.csr_out, 32'h0002_0004); end
    tick();
    set_csr(1'b1, BASE + NCH, CSRRC, 32'h0002_0000);
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0002_0004) begin errors++; $display("FAIL ovr_rc_noeffect act=%h exp=%h", csr.csr_out, 32'h0002_0004); end
    tick();
    set_csr(1'b1, BASE + 2, CSRRW, 32'hFFFF);
    checks++; if (csr.csr_out !== 32'h0777) begin errors++; $display("FAIL ovr_latest act=%h exp=%h", csr.csr_out, 32'h0777); end
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 32'h0002_0000);
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL ovr_rs_clear act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    set_csr(1'b1, BASE + 2, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0777) begin errors++; $display("FAIL stamp_ro act=%h exp=%h", csr.csr_out, 32'h0777); end
    tick();
    idle();
  endtask

  task automatic test_read_and_edge();
    mono_timer = 64'h8880; pend[3] = 1'b1;
    tick();
    pend[3] = 1'b0;
    tick();
    mono_timer = 64'h9990; pend[3] = 1'b1;
    set_csr(1'b1, BASE + 3, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0888) begin errors++; $display("FAIL rdedge_old act=%h exp=%h", csr.csr_out, 32'h0888); end
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0000_0008) begin errors++; $display("FAIL rdedge_status act=%h exp=%h", csr.csr_out, 32'h0000_0008); end
    tick();
    set_csr(1'b1, BASE + 3, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0999) begin errors++; $display("FAIL rdedge_new act=%h exp=%h", csr.csr_out, 32'h0999); end
    pend[3] = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_wrap_unmapped();
    mono_timer = 64'h000F_FFF0; pend[4] = 1'b1;
    tick();
    pend[4] = 1'b0;
    set_csr(1'b1, BASE + 4, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'hFFFF) begin errors++; $display("FAIL wrap_hi act=%h exp=%h", csr.csr_out, 32'hFFFF); end
    tick();
    idle();
    mono_timer = 64'h0010_0000; pend[4] = 1'b1;
    tick();
    pend[4] = 1'b0;
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h10) begin errors++; $display("FAIL wrap_valid act=%h exp=%h", csr.csr_out, 32'h10); end
    tick();
    set_csr(1'b1, BASE + 4, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL wrap_zero act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    set_csr(1'b1, BASE + NCH + 2, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL unmapped act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    set_csr(1'b1, BASE + NCH + 1, CSRRW, 32'hFF);
    tick();
    set_csr(1'b1, BASE + NCH + 1, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h00FF) begin errors++; $display("FAIL mode_ff act=%h exp=%h", csr.csr_out, 32'h00FF); end
    tick();
    idle();
    pend[0] = 1'b1;
    tick();
    pend[0] = 1'b0;
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0001_0001) begin errors++; $display("FAIL premid_status act=%h exp=%h", csr.csr_out, 32'h0001_0001); end
    idle();
    mono_timer = 64'h1110; pend[0] = 1'b1; pend[6] = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; mono_timer = 64'hABC0;
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL mid_status act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    mono_timer = 64'hB000;
    set_csr(1'b1, BASE + NCH + 1, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h5555) begin errors++; $display("FAIL mid_mode act=%h exp=%h", csr.csr_out, 32'h5555); end
    tick();
    set_csr(1'b1, BASE + NCH, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h41) begin errors++; $display("FAIL post_status act=%h exp=%h", csr.csr_out, 32'h41); end
    tick();
    set_csr(1'b1, BASE + 0, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0ABC) begin errors++; $display("FAIL post_stamp0 act=%h exp=%h", csr.csr_out, 32'h0ABC); end
    tick();
    set_csr(1'b1, BASE + 6, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0ABC) begin errors++; $display("FAIL post_stamp6 act=%h exp=%h", csr.csr_out, 32'h0ABC); end
    tick();
    set_csr(1'b1, BASE + 1, CSRRS, 0);
    checks++; if (csr.csr_out !== 32'h0) begin errors++; $display("FAIL post_stamp1 act=%h exp=%h", csr.csr_out, 32'h0); end
    tick();
    idle();
    for (int unsigned k = 0; k < NCH; k++) pend[k] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int unsigned addr, exp, sel, data;
    for (int n = 0; n < 400; n++) begin
      mono_timer = mono_timer + MonoTimerT'($urandom_range(0, 300));
      for (int unsigned k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 3) == 0) pend[k] = ~pend[k];
      end
      addr = BASE + $urandom_range(0, NCH + 3);
      sel  = $urandom_range(0, 3);
      data = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      set_csr($urandom_range(0, 1) == 1, addr, CsrOpT'(sel), data);
      exp = model_read(addr);
      checks++;
      if (csr.csr_out !== exp) begin
        errors++;
        $display("FAIL rand_read n=%0d addr=%h act=%h exp=%h", n, addr, csr.csr_out, exp);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    mono_timer = '0;
    for (int unsigned k = 0; k < NCH; k++) pend[k] = 1'b0;
    csr.csr_enable = 1'b0;
    csr.csr_addr   = '0;
    csr.csr_op     = CSR_NONE;
    csr.rs1_data   = '0;
    test_reset();
    test_rise_capture();
    test_fall_both();
    test_overrun_w1c();
    test_read_and_edge();
    test_wrap_unmapped();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
